// File: rtl/hu_pipeline_pkg.sv
// Shared types for the elastic pipeline: per-stage occupancy state.
package hu_pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } hu_stage_state_t;

endpackage

// File: rtl/hu_skid_stage.sv
// One skid stage: main + skid register, 1-cycle latency when BUSY.
// in_ready/out_valid come from registered state only, so out_ready never reaches in_ready.
module hu_skid_stage
  import hu_pipeline_pkg::*;
#(
  parameter type regtype = bit [7:0]
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   in_valid,
  output logic   in_ready,
  input  regtype in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output regtype out_data
);

  hu_stage_state_t state;
  regtype          main_q;
  regtype          skid_q;
  logic            in_xfer;
  logic            out_xfer;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state  <= BUSY;
            main_q <= in_data;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (in_xfer) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // Skid item moves up; the freed skid reopens input next cycle.
          if (out_xfer) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/hu_pipeline_elastic.sv
// Elastic chain of depth skid stages (capacity 2*depth) with flush and occupancy count.
// Latency depth cycles when unstalled; stalls propagate back one stage per cycle.
module hu_pipeline_elastic
  import hu_pipeline_pkg::*;
#(
  parameter  int  depth   = 1,
  parameter  type regtype = bit [7:0],
  localparam int  cw      = $clog2(2 * depth + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  regtype        in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output regtype        out_data,
  output logic [cw-1:0] count
);

  logic   vld [0:depth];
  logic   rdy [0:depth];
  regtype dat [0:depth];
  logic   in_xfer;
  logic   out_xfer;

  assign vld[0]     = in_valid;
  assign dat[0]     = in_data;
  assign in_ready   = rdy[0];
  assign rdy[depth] = out_ready;
  assign out_valid  = vld[depth];
  assign out_data   = dat[depth];

  for (genvar k = 0; k < depth; k++) begin : g_stage
    hu_skid_stage #(
      .regtype(regtype)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (vld[k]),
      .in_ready (rdy[k]),
      .in_data  (dat[k]),
      .out_valid(vld[k+1]),
      .out_ready(rdy[k+1]),
      .out_data (dat[k+1])
    );
  end

  assign in_xfer  = in_valid & rdy[0];
  assign out_xfer = vld[depth] & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + cw'(in_xfer) - cw'(out_xfer);
    end
  end

endmodule

// File: doc/hu_pipeline_elastic.md
# hu_pipeline_elastic

Elastic, back-pressured counterpart to the fixed-latency pipeline register: a chain of `depth` skid-buffer stages carrying `regtype` payloads under a valid/ready handshake. It sits directly downstream of a fixed-latency pipeline register, decoupling a free-running datapath from a consumer that may stall. It sustains one transfer per cycle with no combinational path from `out_ready` to `in_ready`. It also provides a synchronous flush and an occupancy count.

## Interface
- `depth`, 1: number of skid stages (≥1); capacity is 2·`depth` items.
- `regtype`, `bit[7:0]`: payload type.
- `clk`  in  1  pipeline clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high; one clock domain only.
- `flush`  in  1  synchronous clear of all stages.
- `in_valid`  in  1  upstream has data.
- `in_ready`  out  1  block accepts data this cycle.
- `in_data`  in  `regtype`  upstream payload.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts data this cycle.
- `out_data`  out  `regtype`  payload at the head of the chain.
- `count`  out  $clog2(2·`depth`+1)  number of items currently held.

## Operation
- Transfer happens on a rising edge when valid and ready are both high; this rule applies independently on the input and output sides.
- Each stage holds a main register and a skid register. Its state is one of:
  - EMPTY: main invalid.
  - BUSY: main valid, skid empty.
  - FULL: both registers valid.
- Stage outputs: `s_ready` = (state≠FULL); `s_valid` = (state≠EMPTY); `s_data` = main.
- Stage transitions (i = input transfer, o = output transfer):
  - EMPTY: i → BUSY, main←in.
  - BUSY: i&o → BUSY, main←in. i&!o → FULL, skid←in. !i&o → EMPTY. Otherwise hold.
  - FULL: input is blocked. o → BUSY, main←skid. Otherwise hold.
- Chaining: stage k's output feeds stage k+1's input. `in_*` connects to stage 0 and `out_*` to stage `depth`−1.
- `count` = Σ over stages of (BUSY→1, FULL→2). It is updated each cycle by +i −o and is never computed combinationally from the inputs.
- `flush` (priority over all transfers): every stage goes to EMPTY and `count` goes to 0 on that edge.
  - An input presented in the flush cycle is dropped. `in_ready` still reflects the pre-flush state.
  - An output transfer in the flush cycle counts as delivered.
- Data ordering is strict FIFO. No payload is ever duplicated or lost except by `flush` or `rst`.

## Timing
- Reset values:
  - All stages EMPTY.
  - `out_valid`=0, `in_ready`=1, `count`=0, `out_data`='0, skid data='0.
  - Handshakes while `rst` is high are ignored.
- Reset mid-operation empties the chain immediately (asynchronous). The first legal transfer is on the first edge after deassertion.
- Latency: an item accepted at edge N appears on `out_valid` after edge N+`depth`−1, i.e. visible in cycle N+`depth` with `out_ready` held high throughout.
- Throughput: 1 item/cycle sustained with `out_ready`=1.
- `in_ready` and `out_valid` are functions of registered state only. There is no in→out or ready→ready combinational path.
- Full: `count`=2·`depth` ⇒ `in_ready`=0. If `out_ready` rises, `in_ready` rises no sooner than the next cycle.
- Empty: `out_valid`=0. `out_ready` has no effect.
- Simultaneous accept and deliver leave `count` unchanged.

## Structure
- Shared package `hu_pipeline_pkg`: typedef `hu_stage_state_t` enum {EMPTY, BUSY, FULL}.
- Sub-module `hu_skid_stage` (parameter `regtype`): one stage with clk/rst/flush and an in/out handshake.
- Top level: generate-loop chain of `depth` stages, plus the `count` register.

## Test plan
- Reset then stream 0x01..0x10 with `out_ready`=1, `depth`=3 → first `out_valid` with 0x01 three cycles after the first accept. Output is one item per cycle in order. `count` stays at 3 in steady state.
- Hold `out_ready`=0 while offering 0x20.. with `depth`=2 → accepts exactly 4 items (0x20–0x23). `in_ready`=0 thereafter and `count`=4. Releasing `out_ready` delivers 0x20..0x23 in order, with `in_ready`=1 one cycle after release.
- Random `in_valid`/`out_ready` (50%), 10k items, `depth`=1..4 → scoreboard order match, no loss, `count` equal to the model each cycle.
- Fill 3 items, then assert `flush` with `in_valid`=1 and data 0xAA → next cycle `out_valid`=0 and `count`=0. 0xAA is never emitted.
- Assert `rst` asynchronously mid-stream with `count`=5 → `out_valid`=0 and `count`=0 before the next edge. Traffic after deassertion starts cleanly from the new data.
- Formal/assertion check: `in_ready` never depends combinationally on `out_ready`. `count` ≤ 2·`depth`.
